// File: rtl/pipe_ex2_pkg.sv
// Shared widths, ALU function codes and per-stage pipeline register layouts
// for the pipe_ex2 four-stage datapath.
package pipe_ex2_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int MEM_AW = 8;
  localparam int FUNC_W = 4;

  localparam logic [FUNC_W-1:0] FN_ADD  = 4'd0;
  localparam logic [FUNC_W-1:0] FN_SUB  = 4'd1;
  localparam logic [FUNC_W-1:0] FN_MUL  = 4'd2;
  localparam logic [FUNC_W-1:0] FN_PASA = 4'd3;
  localparam logic [FUNC_W-1:0] FN_PASB = 4'd4;
  localparam logic [FUNC_W-1:0] FN_AND  = 4'd5;
  localparam logic [FUNC_W-1:0] FN_OR   = 4'd6;
  localparam logic [FUNC_W-1:0] FN_XOR  = 4'd7;
  localparam logic [FUNC_W-1:0] FN_NEGA = 4'd8;
  localparam logic [FUNC_W-1:0] FN_NEGB = 4'd9;
  localparam logic [FUNC_W-1:0] FN_SHR  = 4'd10;
  localparam logic [FUNC_W-1:0] FN_SHL  = 4'd11;
  localparam logic [FUNC_W-1:0] FN_ROL  = 4'd12;
  localparam logic [FUNC_W-1:0] FN_ROR  = 4'd13;
  localparam logic [FUNC_W-1:0] FN_INC  = 4'd14;
  localparam logic [FUNC_W-1:0] FN_EQ   = 4'd15;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [FUNC_W-1:0] func;
    logic [MEM_AW-1:0] addr;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } s1_reg_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [MEM_AW-1:0] addr;
    logic [DATA_W-1:0] z;
  } s2_reg_t;

  typedef struct packed {
    logic              valid;
    logic [MEM_AW-1:0] addr;
    logic [DATA_W-1:0] z;
  } s3_reg_t;

endpackage

// File: rtl/pipe_ex2_alu.sv
// Combinational ALU for pipe_ex2. Defining PIPE_EX2_EXT_OPS_EN enables the
// rotate/increment/compare codes 12-15; otherwise those codes yield zero.
module pipe_ex2_alu
  import pipe_ex2_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [FUNC_W-1:0] i_func,
  output logic [DATA_W-1:0] o_z
);

  always_comb begin
    o_z = '0;
    case (i_func)
      FN_ADD:  o_z = i_a + i_b;
      FN_SUB:  o_z = i_a - i_b;
      FN_MUL:  o_z = i_a * i_b;
      FN_PASA: o_z = i_a;
      FN_PASB: o_z = i_b;
      FN_AND:  o_z = i_a & i_b;
      FN_OR:   o_z = i_a | i_b;
      FN_XOR:  o_z = i_a ^ i_b;
      FN_NEGA: o_z = ~i_a;
      FN_NEGB: o_z = ~i_b;
      FN_SHR:  o_z = i_a >> 1;
      FN_SHL:  o_z = i_a << 1;
`ifdef PIPE_EX2_EXT_OPS_EN
      FN_ROL:  o_z = {i_a[DATA_W-2:0], i_a[DATA_W-1]};
      FN_ROR:  o_z = {i_a[0], i_a[DATA_W-1:1]};
      FN_INC:  o_z = i_a + DATA_W'(1);
      FN_EQ:   o_z = {{(DATA_W-1){1'b0}}, (i_a == i_b)};
`endif
      default: o_z = '0;
    endcase
  end

endmodule

// File: rtl/pipe_ex2_core.sv
// Four-stage read/execute/write-back/store pipeline around a 16x16 register
// bank and 256x16 data memory. PIPE_EX2_EXT_OPS_EN is consumed by pipe_ex2_alu.
module pipe_ex2_core
  import pipe_ex2_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [FUNC_W-1:0] i_func,
  input  logic [MEM_AW-1:0] i_addr,
  output logic [DATA_W-1:0] o_zout
);

  logic [DATA_W-1:0] regbank [0:15];
  logic [DATA_W-1:0] mem     [0:255];

  s1_reg_t           r_s1;
  s2_reg_t           r_s2;
  s3_reg_t           r_s3;
  logic [DATA_W-1:0] r_zout;

  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_z;

  // The write-back stage writes from the S2 register on the same edge that S1
  // samples, so a matching read index takes the in-flight value.
  assign w_a = (r_s2.valid && (r_s2.rd == i_rs1)) ? r_s2.z : regbank[i_rs1];
  assign w_b = (r_s2.valid && (r_s2.rd == i_rs2)) ? r_s2.z : regbank[i_rs2];

  pipe_ex2_alu u_alu (
    .i_a    (r_s1.a),
    .i_b    (r_s1.b),
    .i_func (r_s1.func),
    .o_z    (w_z)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_zout <= '0;
    end else begin
      r_s1.valid <= 1'b1;
      r_s1.rd    <= i_rd;
      r_s1.func  <= i_func;
      r_s1.addr  <= i_addr;
      r_s1.a     <= w_a;
      r_s1.b     <= w_b;

      r_s2.valid <= r_s1.valid;
      r_s2.rd    <= r_s1.rd;
      r_s2.addr  <= r_s1.addr;
      r_s2.z     <= w_z;

      r_s3.valid <= r_s2.valid;
      r_s3.addr  <= r_s2.addr;
      r_s3.z     <= r_s2.z;
      if (r_s2.valid) begin
        r_zout <= r_s2.z;
      end
    end
  end

  // Array contents survive reset; only the writes are suppressed.
  always_ff @(posedge i_clk) begin
    if (!i_rst && r_s2.valid) begin
      regbank[r_s2.rd] <= r_s2.z;
    end
    if (!i_rst && r_s3.valid) begin
      mem[r_s3.addr] <= r_s3.z;
    end
  end

  assign o_zout = r_zout;

endmodule

// File: tb/tb_pipe_ex2_core.sv
// Scoreboard bench for pipe_ex2_core: directed vectors with hand-computed results.
module tb_pipe_ex2_core;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_rs1, i_rs2, i_rd, i_func;
  logic [7:0]  i_addr;
  logic [15:0] o_zout;

  pipe_ex2_core dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_rs1  (i_rs1),
    .i_rs2  (i_rs2),
    .i_rd   (i_rd),
    .i_func (i_func),
    .i_addr (i_addr),
    .o_zout (o_zout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  rd;
    logic [7:0]  addr;
    logic [15:0] z;
  } exp_t;

  exp_t q_wb[$];
  exp_t q_st[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic tb_issue = 1'b0;
  logic [3:0] vpipe = 4'b0;

`ifdef PIPE_EX2_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Idle instruction only touches scratch register 11 and mem[255].
  task automatic drive_idle();
    @(negedge i_clk);
    i_rs1 = 4'd11; i_rs2 = 4'd11; i_rd = 4'd11; i_func = 4'd3; i_addr = 8'd255;
    tb_issue = 1'b0;
  endtask

  task automatic issue(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                       input logic [3:0] fn, input logic [7:0] ad, input logic [15:0] z);
    exp_t e;
    @(negedge i_clk);
    i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_func = fn; i_addr = ad;
    tb_issue = 1'b1;
    e.rd = rd; e.addr = ad; e.z = z;
    q_wb.push_back(e);
  endtask

  task automatic drive_raw(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                           input logic [3:0] fn, input logic [7:0] ad);
    @(negedge i_clk);
    i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_func = fn; i_addr = ad;
    tb_issue = 1'b0;
  endtask

  // Timing of issued instructions: zout/regbank after 3 edges, mem after 4.
  always @(posedge i_clk) begin
    if (i_rst) vpipe <= 4'b0;
    else       vpipe <= {vpipe[2:0], tb_issue};
  end

  always @(negedge i_clk) begin
    exp_t e;
    if (vpipe[3]) begin
      if (q_st.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL st_queue actual=empty expected=entry");
      end else begin
        e = q_st.pop_front();
        check($sformatf("mem[%0d]", e.addr), dut.mem[e.addr], e.z);
      end
    end
    if (vpipe[2]) begin
      if (q_wb.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL wb_queue actual=empty expected=entry");
      end else begin
        e = q_wb.pop_front();
        check("zout", o_zout, e.z);
        check($sformatf("regbank[%0d]", e.rd), dut.regbank[e.rd], e.z);
        q_st.push_back(e);
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    i_rs1 = 4'd11; i_rs2 = 4'd11; i_rd = 4'd11; i_func = 4'd3; i_addr = 8'd255;
    for (int k = 0; k < 16; k++) dut.regbank[k] = 16'(k);
    dut.regbank[11] = 16'h5A5A;
    for (int k = 0; k < 256; k++) dut.mem[k] = 16'hAAAA;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_zout", o_zout, 16'h0000);
    i_rst = 1'b0;

    issue(4'd3,  4'd5,  4'd10, 4'd0,  8'd125, 16'd8);
    issue(4'd3,  4'd8,  4'd12, 4'd2,  8'd126, 16'd24);
    issue(4'd10, 4'd5,  4'd14, 4'd1,  8'd128, 16'd3);
    issue(4'd7,  4'd3,  4'd13, 4'd11, 8'd127, 16'd14);
    issue(4'd10, 4'd5,  4'd15, 4'd1,  8'd129, 16'd3);
    issue(4'd12, 4'd13, 4'd0,  4'd0,  8'd130, 16'd38);
    drive_idle();
    repeat (8) @(negedge i_clk);
    check("regbank[0]_final", dut.regbank[0], 16'd38);

    // Two instructions in flight when reset hits; a third sits on the reset edge.
    drive_raw(4'd1, 4'd2, 4'd6, 4'd0, 8'd240);
    drive_raw(4'd3, 4'd3, 4'd9, 4'd0, 8'd241);
    drive_raw(4'd1, 4'd1, 4'd8, 4'd0, 8'd242);
    i_rst = 1'b1;
    drive_idle();
    i_rst = 1'b0;
    check("rst_zout", o_zout, 16'h0000);
    @(negedge i_clk);
    check("rst_zout_hold", o_zout, 16'h0000);
    repeat (5) @(negedge i_clk);
    check("rst_regbank[6]", dut.regbank[6], 16'd6);
    check("rst_regbank[9]", dut.regbank[9], 16'd9);
    check("rst_regbank[8]", dut.regbank[8], 16'd8);
    check("rst_mem[240]", dut.mem[240], 16'hAAAA);
    check("rst_mem[241]", dut.mem[241], 16'hAAAA);
    check("rst_mem[242]", dut.mem[242], 16'hAAAA);
    check("idle_zout", o_zout, 16'h5A5A);

    dut.regbank[1] = 16'hF0F0;
    dut.regbank[2] = 16'h0FF3;
    dut.regbank[4] = 16'h8001;
    issue(4'd1, 4'd2, 4'd3, 4'd0,  8'd200, 16'h00E3);
    issue(4'd1, 4'd2, 4'd3, 4'd1,  8'd201, 16'hE0FD);
    issue(4'd1, 4'd2, 4'd3, 4'd2,  8'd202, 16'hC3D0);
    issue(4'd1, 4'd2, 4'd3, 4'd3,  8'd203, 16'hF0F0);
    issue(4'd1, 4'd2, 4'd3, 4'd4,  8'd204, 16'h0FF3);
    issue(4'd1, 4'd2, 4'd3, 4'd5,  8'd205, 16'h00F0);
    issue(4'd1, 4'd2, 4'd3, 4'd6,  8'd206, 16'hFFF3);
    issue(4'd1, 4'd2, 4'd3, 4'd7,  8'd207, 16'hFF03);
    issue(4'd1, 4'd2, 4'd3, 4'd8,  8'd208, 16'h0F0F);
    issue(4'd1, 4'd2, 4'd3, 4'd9,  8'd209, 16'hF00C);
    issue(4'd1, 4'd2, 4'd3, 4'd10, 8'd210, 16'h7878);
    issue(4'd1, 4'd2, 4'd3, 4'd11, 8'd211, 16'hE1E0);
    issue(4'd4, 4'd2, 4'd3, 4'd12, 8'd212, EXT ? 16'h0003 : 16'h0000);
    issue(4'd1, 4'd2, 4'd3, 4'd13, 8'd213, EXT ? 16'h7878 : 16'h0000);
    issue(4'd1, 4'd2, 4'd3, 4'd14, 8'd214, EXT ? 16'hF0F1 : 16'h0000);
    issue(4'd1, 4'd1, 4'd3, 4'd15, 8'd215, EXT ? 16'h0001 : 16'h0000);
    drive_idle();
    repeat (8) @(negedge i_clk);

    check("wb_queue_drained", 16'(q_wb.size()), 16'd0);
    check("st_queue_drained", 16'(q_st.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
